// File: rtl/sottrattore_seriale_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sottrattore_seriale_pkg
// Purpose  : Shared definitions for the bit-serial subtractor: default operand
//            width and the 2-bit FSM state encoding.
// Contents : ARIT_N_DEFAULT   - default operand/result width (8)
//            state_t          - ST_IDLE / ST_RUN / ST_DONE
// Revision : 1.0 - initial release
// ============================================================================
package sottrattore_seriale_pkg;

    localparam int ARIT_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sottrattore_seriale_sottrattore.sv
`default_nettype none
// ============================================================================
// Module   : sottrattore
// Purpose  : 1-bit full subtractor cell (a - b - prestito_in), written as two
//            explicit truth tables, one per output.
// Ports    : a, b, prestito_in  - operand bits and incoming borrow
//            differenza         - difference bit
//            prestito_out       - outgoing borrow
// Revision : 1.0 - initial release
// ============================================================================
module sottrattore (
    input  logic a,
    input  logic b,
    input  logic prestito_in,
    output logic differenza,
    output logic prestito_out
);

    // Difference table: odd parity of the three inputs.
    always_comb begin
        differenza = 1'b0;
        case ({a, b, prestito_in})
            3'b000: differenza = 1'b0;
            3'b001: differenza = 1'b1;
            3'b010: differenza = 1'b1;
            3'b011: differenza = 1'b0;
            3'b100: differenza = 1'b1;
            3'b101: differenza = 1'b0;
            3'b110: differenza = 1'b0;
            3'b111: differenza = 1'b1;
            default: differenza = 1'b0;
        endcase
    end

    // Borrow table: borrow whenever b + prestito_in exceeds a.
    always_comb begin
        prestito_out = 1'b0;
        case ({a, b, prestito_in})
            3'b000: prestito_out = 1'b0;
            3'b001: prestito_out = 1'b1;
            3'b010: prestito_out = 1'b1;
            3'b011: prestito_out = 1'b1;
            3'b100: prestito_out = 1'b0;
            3'b101: prestito_out = 1'b0;
            3'b110: prestito_out = 1'b0;
            3'b111: prestito_out = 1'b1;
            default: prestito_out = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sottrattore_seriale.sv
`default_nettype none
// ============================================================================
// Module   : sottrattore_seriale
// Purpose  : Bit-serial N-bit subtractor, d = a - b - prestito_in, one bit per
//            clock LSB first, with start/occupato/pronto handshake.
// Ports    : clk, rst (sync, active-high)
//            start, a[N-1:0], b[N-1:0], prestito_in - request and operands
//            d[N-1:0], prestito, ovf                 - registered results
//            occupato                                - operation in progress
//            pronto                                  - 1-cycle result strobe
// Revision : 1.0 - initial release
// ============================================================================
module sottrattore_seriale
    import sottrattore_seriale_pkg::*;
#(
    parameter int N = ARIT_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         prestito_in,
    output logic [N-1:0] d,
    output logic         prestito,
    output logic         ovf,
    output logic         occupato,
    output logic         pronto
);

    localparam int             C_CNT_W = $clog2(N + 1);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(N - 1);

    state_t             r_state;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic [N-1:0]       r_res;
    logic               r_br;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_sa;
    logic               r_sb;

    logic               w_diff;
    logic               w_br;
    logic [N-1:0]       w_res_next;

    sottrattore u_cell (
        .a            (r_a[0]),
        .b            (r_b[0]),
        .prestito_in  (r_br),
        .differenza   (w_diff),
        .prestito_out (w_br)
    );

    // The final bit is merged straight into the output registers on the last
    // RUN edge, so pronto rises exactly N edges after the accepting edge.
    assign w_res_next = {w_diff, r_res[N-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            d        <= '0;
            prestito <= 1'b0;
            ovf      <= 1'b0;
            occupato <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    pronto <= 1'b0;
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_br     <= prestito_in;
                        r_cnt    <= '0;
                        r_sa     <= a[N-1];
                        r_sb     <= b[N-1];
                        occupato <= 1'b1;
                        r_state  <= ST_RUN;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_res <= w_res_next;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        d        <= w_res_next;
                        prestito <= w_br;
                        // Overflow only possible when operand signs differ and
                        // the result sign disagrees with the minuend.
                        ovf      <= (r_sa != r_sb) && (w_diff != r_sa);
                        occupato <= 1'b0;
                        pronto   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                default: begin
                    occupato <= 1'b0;
                    pronto   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
